// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response channel types
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/tinyodin_pkg.sv
// rtl/tinyodin_pkg.sv - tinyODIN region map, FSM states and depth lookup
package tinyodin_pkg;

    typedef enum logic [1:0] {
        REGION_SPIKE   = 2'd0,
        REGION_NEURON  = 2'd1,
        REGION_SYNAPSE = 2'd2,
        REGION_CTRL    = 2'd3
    } region_e;

    localparam int unsigned SPIKE_DEPTH   = 64;
    localparam int unsigned SYNAPSE_DEPTH = 8192;
    localparam int unsigned CTRL_DEPTH    = 1;
    localparam logic [31:0] CTRL_ADDR     = 32'h0030_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DREQ,
        S_DRSP,
        S_CREQ,
        S_CRSP,
        S_DONE
    } state_e;

    // Neuron depth is a build parameter, so it is passed in rather than fixed here.
    function automatic logic [14:0] region_depth(input region_e region, input int unsigned n);
        case (region)
            REGION_SPIKE:   return 15'(SPIKE_DEPTH);
            REGION_NEURON:  return 15'(n);
            REGION_SYNAPSE: return 15'(SYNAPSE_DEPTH);
            default:        return 15'(CTRL_DEPTH);
        endcase
    endfunction

endpackage

// File: rtl/tinyodin_addr_gen.sv
// rtl/tinyodin_addr_gen.sv - region/word index to OBI byte address mapper
module tinyodin_addr_gen
    import tinyodin_pkg::*;
(
    input  logic [1:0]  region,
    input  logic [13:0] idx,
    input  logic        ctrl_sel,
    output logic [31:0] addr
);

    always_comb begin
        if (ctrl_sel) begin
            addr = CTRL_ADDR;
        end else begin
            addr = {10'b0, region, 18'(idx), 2'b00};
        end
    end

endmodule

// File: rtl/tinyodin_cfg_seq.sv
// rtl/tinyodin_cfg_seq.sv - command-driven OBI write sequencer for tinyODIN configuration
module tinyodin_cfg_seq
    import tinyodin_pkg::*;
#(
    parameter int unsigned N     = 256,
    parameter type         req_t = obi_pkg::obi_req_t,
    parameter type         rsp_t = obi_pkg::obi_resp_t
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_region_i,
    input  logic [12:0] cmd_base_i,
    input  logic [13:0] cmd_count_i,
    input  logic        cmd_mode_i,
    input  logic [31:0] cmd_fill_i,
    input  logic        cmd_start_i,
    input  logic [31:0] cmd_ctrl_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    input  logic [31:0] wdata_i,
    output req_t        obi_req_o,
    input  rsp_t        obi_rsp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e      state;
    region_e     region_q;
    logic [12:0] base_q;
    logic [13:0] count_q;
    logic        mode_q;
    logic [31:0] fill_q;
    logic        start_q;
    logic [31:0] ctrl_q;
    logic [13:0] beat_q;
    logic        req_q;
    logic        err_q;

    logic [14:0] end_idx;
    logic [14:0] depth;
    logic [13:0] idx;
    logic [31:0] addr;
    logic        ctrl_phase;
    logic        data_avail;
    logic        req_valid;
    logic        granted;
    logic        last_beat;
    logic        rdata_unused;

    // 15-bit sum so a large base+count can never wrap back into range.
    assign end_idx    = {2'b00, base_q} + {1'b0, count_q};
    assign depth      = region_depth(region_q, N);
    assign idx        = {1'b0, base_q} + beat_q;
    assign ctrl_phase = (state == S_CREQ);
    assign data_avail = ctrl_phase || !mode_q || wdata_valid_i;
    assign req_valid  = req_q && data_avail;
    assign granted    = req_valid && obi_rsp_i.gnt;
    assign last_beat  = ((beat_q + 14'd1) == count_q);

    assign rdata_unused = ^obi_rsp_i.rdata;

    tinyodin_addr_gen u_addr_gen (
        .region   (region_q),
        .idx      (idx),
        .ctrl_sel (ctrl_phase),
        .addr     (addr)
    );

    always_comb begin
        obi_req_o       = '0;
        obi_req_o.req   = req_valid;
        obi_req_o.we    = req_q;
        obi_req_o.be    = req_q ? 4'hF : 4'h0;
        obi_req_o.addr  = addr;
        obi_req_o.wdata = ctrl_phase ? ctrl_q : (mode_q ? wdata_i : fill_q);
    end

    // Stream words are consumed exactly when the slave takes the data beat.
    assign wdata_ready_o = granted && mode_q && (state == S_DREQ);
    assign cmd_ready_o   = (state == S_IDLE);
    assign busy_o        = (state != S_IDLE);
    assign done_o        = (state == S_DONE);
    assign err_o         = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            region_q <= REGION_SPIKE;
            base_q   <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            fill_q   <= '0;
            start_q  <= 1'b0;
            ctrl_q   <= '0;
            beat_q   <= '0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        region_q <= region_e'(cmd_region_i);
                        base_q   <= cmd_base_i;
                        count_q  <= cmd_count_i;
                        mode_q   <= cmd_mode_i;
                        fill_q   <= cmd_fill_i;
                        start_q  <= cmd_start_i;
                        ctrl_q   <= cmd_ctrl_i;
                        beat_q   <= '0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (region_q == REGION_CTRL || end_idx > depth) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else if (count_q == 14'd0) begin
                        if (start_q) begin
                            req_q <= 1'b1;
                            state <= S_CREQ;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        req_q <= 1'b1;
                        state <= S_DREQ;
                    end
                end
                S_DREQ: begin
                    if (granted) begin
                        req_q <= 1'b0;
                        state <= S_DRSP;
                    end
                end
                S_DRSP: begin
                    if (obi_rsp_i.rvalid) begin
                        beat_q <= beat_q + 14'd1;
                        if (!last_beat) begin
                            req_q <= 1'b1;
                            state <= S_DREQ;
                        end else if (start_q) begin
                            req_q <= 1'b1;
                            state <= S_CREQ;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_CREQ: begin
                    if (granted) begin
                        req_q <= 1'b0;
                        state <= S_CRSP;
                    end
                end
                S_CRSP: begin
                    if (obi_rsp_i.rvalid) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    req_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
